tdm_demux_1to4: RTL and testbench

Time-division demultiplexer: receives a 1-bit serial stream, one lane bit per accepted cycle, and distributes it round-robin into four registered lane outputs. It is the receive-side counterpart of the 2:1/4:1 mux slicing used on the transmit path. A frame is complete after four accepted bits, at which point all four lanes update together and a one-cycle valid pulse is raised. An optional sync input realigns the slot counter to slot 0.

---
 rtl/tdm_pkg.sv | 10 +
 rtl/and_gate.sv | 13 +
 rtl/demux_1to4_1bit.sv | 32 +++
 rtl/dff_en.sv | 29 ++
 rtl/not_gate.sv | 12 +
 rtl/tdm_demux_1to4.sv | 98 +++++++++
 tb/tb_tdm_demux_1to4.sv | 204 ++++++++++++++++++++
 7 files changed

// File: rtl/tdm_pkg.sv
// tdm_pkg: slot geometry shared by the TDM receive demux and transmit mux.
// Latency: n/a (constants only).
// Backpressure: n/a.
package tdm_pkg;

  localparam int unsigned SLOT_W    = 2;
  localparam int unsigned NUM_SLOTS = 4;
  localparam logic [SLOT_W-1:0] LAST_SLOT = 2'd3;

endpackage : tdm_pkg

// File: rtl/and_gate.sv
// and_gate: two-input AND primitive.
// Latency: combinational.
// Backpressure: none.
// Ports: a_i, b_i inputs, y_o = a_i & b_i.
module and_gate (
  input  logic a_i,
  input  logic b_i,
  output logic y_o
);

  assign y_o = a_i & b_i;

endmodule : and_gate

// File: rtl/demux_1to4_1bit.sv
// demux_1to4_1bit: decodes a 2-bit slot into four one-hot write enables gated by en_i.
// Latency: combinational.
// Backpressure: none.
// Ports: sel_i slot number, en_i qualifier (accepted bit), we_o[i] high when
//        en_i and sel_i == i.
module demux_1to4_1bit
  import tdm_pkg::*;
(
  input  logic [SLOT_W-1:0]    sel_i,
  input  logic                 en_i,
  output logic [NUM_SLOTS-1:0] we_o
);

  logic sel0_n, sel1_n;
  logic dec0, dec1, dec2, dec3;

  not_gate u_inv0 (.a_i(sel_i[0]), .y_o(sel0_n));
  not_gate u_inv1 (.a_i(sel_i[1]), .y_o(sel1_n));

  // Slot decode: each term is one of the four minterms of sel_i.
  and_gate u_dec0 (.a_i(sel1_n),   .b_i(sel0_n),   .y_o(dec0));
  and_gate u_dec1 (.a_i(sel1_n),   .b_i(sel_i[0]), .y_o(dec1));
  and_gate u_dec2 (.a_i(sel_i[1]), .b_i(sel0_n),   .y_o(dec2));
  and_gate u_dec3 (.a_i(sel_i[1]), .b_i(sel_i[0]), .y_o(dec3));

  // Only an accepted bit may produce a write enable.
  and_gate u_en0 (.a_i(dec0), .b_i(en_i), .y_o(we_o[0]));
  and_gate u_en1 (.a_i(dec1), .b_i(en_i), .y_o(we_o[1]));
  and_gate u_en2 (.a_i(dec2), .b_i(en_i), .y_o(we_o[2]));
  and_gate u_en3 (.a_i(dec3), .b_i(en_i), .y_o(we_o[3]));

endmodule : demux_1to4_1bit

// File: rtl/dff_en.sv
// dff_en: W-bit register with load enable and synchronous active-low reset.
// Latency: 1 cycle from d_i to q_o when en_i is high.
// Backpressure: none; holds value while en_i is low.
// Ports: clk, rst_n (sync, active-low), en_i load enable, d_i next value,
//        q_o registered value (RST_VAL after reset).
module dff_en #(
  parameter int unsigned W = 1,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] q_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q_q <= RST_VAL;
    end else if (en_i) begin
      q_q <= d_i;
    end
  end

  assign q_o = q_q;

endmodule : dff_en

// File: rtl/not_gate.sv
// not_gate: single-bit inverter primitive.
// Latency: combinational.
// Backpressure: none.
// Ports: a_i input bit, y_o inverted output.
module not_gate (
  input  logic a_i,
  output logic y_o
);

  assign y_o = ~a_i;

endmodule : not_gate

// File: rtl/tdm_demux_1to4.sv
// tdm_demux_1to4: 1-bit serial stream distributed round-robin into four registered lanes.
// Latency: lanes and out_valid update on the edge that accepts the slot-3 bit.
// Backpressure: none; one bit accepted every cycle in_valid is high.
// Ports: clk, rst_n (sync, active-low); in serial bit, in_valid accept,
//        sync marks slot 0; out0..out3 lanes of last complete frame,
//        out_valid frame pulse, slot next slot to fill, sync_err misaligned sync pulse.
module tdm_demux_1to4
  import tdm_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in,
  input  logic              in_valid,
  input  logic              sync,
  output logic              out0,
  output logic              out1,
  output logic              out2,
  output logic              out3,
  output logic              out_valid,
  output logic [SLOT_W-1:0] slot,
  output logic              sync_err
);

  logic [SLOT_W-1:0]    slot_q, slot_d, eff_slot;
  logic [NUM_SLOTS-1:0] we;
  logic [LAST_SLOT-1:0] shadow_q;
  logic [NUM_SLOTS-1:0] lanes_q, lanes_d;
  logic                 out_valid_q;
  logic                 sync_err_q, sync_err_d;

  // sync forces the current bit into slot 0; this both aligns the first
  // frame and discards any partial frame on a misaligned sync.
  assign eff_slot = sync ? '0 : slot_q;
  // Natural 2-bit wrap takes slot 3 back to 0.
  assign slot_d   = eff_slot + SLOT_W'(1);

  demux_1to4_1bit u_router (
    .sel_i (eff_slot),
    .en_i  (in_valid),
    .we_o  (we)
  );

  dff_en #(.W(SLOT_W)) u_slot_reg (
    .clk   (clk),
    .rst_n (rst_n),
    .en_i  (in_valid),
    .d_i   (slot_d),
    .q_o   (slot_q)
  );

  // Shadows for slots 0..2; the slot-3 bit goes straight to the lane register.
  for (genvar i = 0; i < int'(LAST_SLOT); i++) begin : g_shadow
    dff_en #(.W(1)) u_shadow_reg (
      .clk   (clk),
      .rst_n (rst_n),
      .en_i  (we[i]),
      .d_i   (in),
      .q_o   (shadow_q[i])
    );
  end

  assign lanes_d = {in, shadow_q[2], shadow_q[1], shadow_q[0]};

  dff_en #(.W(NUM_SLOTS)) u_lanes_reg (
    .clk   (clk),
    .rst_n (rst_n),
    .en_i  (we[LAST_SLOT]),
    .d_i   (lanes_d),
    .q_o   (lanes_q)
  );

  dff_en #(.W(1)) u_out_valid_reg (
    .clk   (clk),
    .rst_n (rst_n),
    .en_i  (1'b1),
    .d_i   (we[LAST_SLOT]),
    .q_o   (out_valid_q)
  );

  assign sync_err_d = in_valid & sync & (slot_q != '0);

  dff_en #(.W(1)) u_sync_err_reg (
    .clk   (clk),
    .rst_n (rst_n),
    .en_i  (1'b1),
    .d_i   (sync_err_d),
    .q_o   (sync_err_q)
  );

  assign out0      = lanes_q[0];
  assign out1      = lanes_q[1];
  assign out2      = lanes_q[2];
  assign out3      = lanes_q[3];
  assign out_valid = out_valid_q;
  assign slot      = slot_q;
  assign sync_err  = sync_err_q;

endmodule : tdm_demux_1to4

// File: tb/tb_tdm_demux_1to4.sv
module tb_tdm_demux_1to4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_b;
  logic       in_valid;
  logic       sync;
  logic       out0, out1, out2, out3;
  logic       out_valid;
  logic [1:0] slot;
  logic       sync_err;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  tdm_demux_1to4 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in        (in_b),
    .in_valid  (in_valid),
    .sync      (sync),
    .out0      (out0),
    .out1      (out1),
    .out2      (out2),
    .out3      (out3),
    .out_valid (out_valid),
    .slot      (slot),
    .sync_err  (sync_err)
  );

  // Lanes packed as {out0,out1,out2,out3} so 4'b1011 reads "1,0,1,1".
  wire [3:0] lanes = {out0, out1, out2, out3};

  // Drive one cycle of stimulus, then step past the edge so outputs are stable.
  task automatic cycle(input logic v, input logic b, input logic s);
    in_valid = v;
    in_b     = b;
    sync     = s;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      cycle(1'b1, 1'b1, 1'b0);
      checks++;
      if ({lanes, out_valid, sync_err, slot} !== 8'h00) begin
        errors++;
        $display("FAIL reset_cycle%0d: lanes=%b ov=%b se=%b slot=%0d, want all 0", i, lanes, out_valid, sync_err, slot);
      end
    end
    rst_n = 1'b1;
    cycle(1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_aligned();
    logic [3:0] bits = 4'b1011;
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, bits[3-i], i == 0);
      checks++;
      if (sync_err !== 1'b0 || slot !== 2'((i + 1) % 4) || out_valid !== (i == 3)) begin
        errors++;
        $display("FAIL aligned_bit%0d: se=%b slot=%0d ov=%b, want se=0 slot=%0d ov=%0d", i, sync_err, slot, out_valid, (i + 1) % 4, i == 3);
      end
    end
    checks++;
    if (lanes !== 4'b1011) begin
      errors++;
      $display("FAIL aligned_lanes: got %b want 1011", lanes);
    end
    cycle(1'b0, 1'b0, 1'b0);
    checks++;
    if (out_valid !== 1'b0 || lanes !== 4'b1011) begin
      errors++;
      $display("FAIL aligned_after: ov=%b lanes=%b, want ov=0 lanes=1011", out_valid, lanes);
    end
  endtask

  task automatic test_gapped();
    logic [3:0] bits = 4'b0110;
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, bits[3-i], 1'b0);
      checks++;
      if (slot !== 2'((i + 1) % 4) || out_valid !== (i == 3)) begin
        errors++;
        $display("FAIL gapped_bit%0d: slot=%0d ov=%b, want slot=%0d ov=%0d", i, slot, out_valid, (i + 1) % 4, i == 3);
      end
      // gap with sync high: must be ignored while in_valid is low
      cycle(1'b0, 1'b1, 1'b1);
      checks++;
      if (slot !== 2'((i + 1) % 4) || out_valid !== 1'b0 || sync_err !== 1'b0) begin
        errors++;
        $display("FAIL gapped_gap%0d: slot=%0d ov=%b se=%b, want slot=%0d ov=0 se=0", i, slot, out_valid, sync_err, (i + 1) % 4);
      end
    end
    checks++;
    if (lanes !== 4'b0110) begin
      errors++;
      $display("FAIL gapped_lanes: got %b want 0110", lanes);
    end
  endtask

  task automatic test_misaligned_sync();
    logic [3:0] bits = 4'b1101;
    int         ov_count = 0;
    cycle(1'b1, 1'b0, 1'b0);
    ov_count += int'(out_valid);
    cycle(1'b1, 1'b0, 1'b0);
    ov_count += int'(out_valid);
    checks++;
    if (slot !== 2'd2) begin
      errors++;
      $display("FAIL missync_pre_slot: got %0d want 2", slot);
    end
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, bits[3-i], i == 0);
      ov_count += int'(out_valid);
      checks++;
      if (sync_err !== (i == 0) || slot !== 2'((i + 1) % 4)) begin
        errors++;
        $display("FAIL missync_bit%0d: se=%b slot=%0d, want se=%0d slot=%0d", i, sync_err, slot, i == 0, (i + 1) % 4);
      end
    end
    checks++;
    if (lanes !== 4'b1101 || out_valid !== 1'b1 || ov_count !== 1) begin
      errors++;
      $display("FAIL missync_frame: lanes=%b ov=%b pulses=%0d, want lanes=1101 ov=1 pulses=1", lanes, out_valid, ov_count);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] bits = 8'b1000_0111;
    for (int i = 0; i < 8; i++) begin
      cycle(1'b1, bits[7-i], 1'b0);
      checks++;
      if (out_valid !== (i == 3 || i == 7)) begin
        errors++;
        $display("FAIL b2b_ov%0d: got %b want %0d", i, out_valid, i == 3 || i == 7);
      end
      if (i >= 3 && i <= 6) begin
        checks++;
        if (lanes !== 4'b1000) begin
          errors++;
          $display("FAIL b2b_hold%0d: lanes=%b want 1000", i, lanes);
        end
      end
    end
    checks++;
    if (lanes !== 4'b0111) begin
      errors++;
      $display("FAIL b2b_frame2: lanes=%b want 0111", lanes);
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [3:0] bits = 4'b0100;
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 1'b0);
    checks++;
    if (slot !== 2'd3) begin
      errors++;
      $display("FAIL rstmid_pre_slot: got %0d want 3", slot);
    end
    rst_n = 1'b0;
    cycle(1'b1, 1'b1, 1'b0);
    rst_n = 1'b1;
    checks++;
    if (slot !== 2'd0 || out_valid !== 1'b0 || lanes !== 4'b0000) begin
      errors++;
      $display("FAIL rstmid_reset: slot=%0d ov=%b lanes=%b, want slot=0 ov=0 lanes=0000", slot, out_valid, lanes);
    end
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, bits[3-i], 1'b0);
      checks++;
      if (out_valid !== (i == 3) || slot !== 2'((i + 1) % 4)) begin
        errors++;
        $display("FAIL rstmid_bit%0d: ov=%b slot=%0d, want ov=%0d slot=%0d", i, out_valid, slot, i == 3, (i + 1) % 4);
      end
    end
    checks++;
    if (lanes !== 4'b0100) begin
      errors++;
      $display("FAIL rstmid_lanes: got %b want 0100", lanes);
    end
  endtask

  initial begin
    rst_n    = 1'b0;
    in_b     = 1'b0;
    in_valid = 1'b0;
    sync     = 1'b0;
    test_reset();
    test_aligned();
    test_gapped();
    test_misaligned_sync();
    test_back_to_back();
    test_reset_mid_frame();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_tdm_demux_1to4
